rom_load_ctrl: RTL and testbench

Download sequencer between `hps_io`'s ioctl stream and the vector-arcade core (`BWIDOW_TOP` and siblings). It routes index-0 bytes into the program and vector ROM write ports and captures the index-1 game-select byte and index-254 DIP bytes. It holds the core in reset through download and a settle period, and releases it only after a length-checked load. It replaces the ad-hoc `mod`/`sw` capture and `rom_download` reset term in the top level.

---
 rtl/bwidow_pkg.sv | 25 ++
 rtl/rom_load_ctrl.sv | 174 +++++++++++++++++
 tb/tb_rom_load_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bwidow_pkg.sv
// Shared types and constants for the vector-arcade download path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bwidow_pkg;

    typedef enum logic [2:0] {
        RLC_IDLE   = 3'd0,
        RLC_LOAD   = 3'd1,
        RLC_SETTLE = 3'd2,
        RLC_RUN    = 3'd3,
        RLC_FAIL   = 3'd4
    } rlc_state_t;

    // hps_io stream indices
    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    // Game select codes carried in the index-1 byte
    localparam logic [7:0] MOD_BWIDOW   = 8'd0;
    localparam logic [7:0] MOD_GRAVITAR = 8'd1;
    localparam logic [7:0] MOD_LUNARBAT = 8'd2;
    localparam logic [7:0] MOD_SPACDUEL = 8'd3;

endpackage

// File: rtl/rom_load_ctrl.sv
// Routes the hps_io download stream into program/vector ROM ports, captures game select and DIPs, sequences core reset.
// Latency: ROM strobes/address/data one cycle after ioctl_wr; core_reset/rom_ready settle SETTLE_CYCLES+1 cycles after download falls.
// Backpressure: none; every ioctl byte is taken the cycle it arrives, out-of-window ROM bytes are counted and dropped.
module rom_load_ctrl
    import bwidow_pkg::*;
#(
    parameter int PROG_BYTES    = 16384,
    parameter int VEC_BYTES     = 8192,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic        clk_12,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        prog_wr,
    output logic        vec_wr,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic [7:0]  mod,
    output logic [63:0] dip_sw,
    output logic        core_reset,
    output logic        rom_ready,
    output logic        load_err
);

    // Settle counter only has to hold SETTLE_CYCLES-1
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [24:0]   PROG_END    = 25'(PROG_BYTES);
    localparam logic [24:0]   IMAGE_BYTES = 25'(PROG_BYTES + VEC_BYTES);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    rlc_state_t    state_q, state_d;
    logic [24:0]   byte_cnt_q, byte_cnt_d;
    logic [SW-1:0] settle_q, settle_d;

    logic          prog_wr_q, prog_wr_d;
    logic          vec_wr_q, vec_wr_d;
    logic [15:0]   dn_addr_q, dn_addr_d;
    logic [7:0]    dn_data_q, dn_data_d;
    logic [7:0]    mod_q, mod_d;
    logic [63:0]   dip_q, dip_d;
    logic          core_reset_q, core_reset_d;
    logic          rom_ready_q, rom_ready_d;
    logic          load_err_q, load_err_d;

    logic          rom_wr;
    logic          in_prog;
    logic          in_vec;
    logic          start_load;
    logic [15:0]   vec_off;
    logic [24:0]   cnt_inc;

    // Decode the incoming byte: only index-0 bytes seen while loading reach the ROM path
    always_comb begin
        rom_wr     = ioctl_wr && (ioctl_index == IDX_ROM) && (state_q == RLC_LOAD);
        in_prog    = (ioctl_addr < PROG_END);
        in_vec     = !in_prog && (ioctl_addr < IMAGE_BYTES);
        vec_off    = 16'(ioctl_addr - PROG_END);
        cnt_inc    = (rom_wr && (byte_cnt_q != '1)) ? byte_cnt_q + 25'd1 : byte_cnt_q;
        start_load = ioctl_download && (ioctl_index == IDX_ROM) && (state_q != RLC_LOAD);
    end

    // ROM write port plus live capture of game select and DIP bytes
    always_comb begin
        prog_wr_d = rom_wr && in_prog;
        vec_wr_d  = rom_wr && in_vec;
        dn_addr_d = dn_addr_q;
        dn_data_d = dn_data_q;
        if (prog_wr_d) begin
            dn_addr_d = ioctl_addr[15:0];
            dn_data_d = ioctl_dout;
        end else if (vec_wr_d) begin
            dn_addr_d = vec_off;
            dn_data_d = ioctl_dout;
        end

        mod_d = mod_q;
        dip_d = dip_q;
        if (ioctl_wr && (ioctl_index == IDX_MOD) && (ioctl_addr == 25'd0)) begin
            mod_d = ioctl_dout;
        end
        if (ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr < 25'd8)) begin
            dip_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
        end
    end

    // Load sequencer: length check on download fall, then settle before releasing the core
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = cnt_inc;
        settle_d   = settle_q;
        load_err_d = load_err_q;

        case (state_q)
            RLC_LOAD: begin
                // cnt_inc already includes a byte strobed in the falling cycle
                if (!ioctl_download) begin
                    if (cnt_inc == IMAGE_BYTES) begin
                        state_d  = RLC_SETTLE;
                        settle_d = SETTLE_LOAD;
                    end else begin
                        state_d    = RLC_FAIL;
                        load_err_d = 1'b1;
                    end
                end
            end
            RLC_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = RLC_RUN;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            default: ;
        endcase

        // A new index-0 download pre-empts whatever the sequencer was doing
        if (start_load) begin
            state_d    = RLC_LOAD;
            byte_cnt_d = '0;
            load_err_d = 1'b0;
        end

        // Registered from next state so the core sees reset the cycle after download rises
        core_reset_d = (state_d != RLC_RUN);
        rom_ready_d  = (state_d == RLC_RUN);
    end

    // State and output registers
    always_ff @(posedge clk_12) begin
        if (reset) begin
            state_q      <= RLC_IDLE;
            byte_cnt_q   <= '0;
            settle_q     <= '0;
            prog_wr_q    <= 1'b0;
            vec_wr_q     <= 1'b0;
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
            mod_q        <= '0;
            dip_q        <= '0;
            core_reset_q <= 1'b1;
            rom_ready_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            settle_q     <= settle_d;
            prog_wr_q    <= prog_wr_d;
            vec_wr_q     <= vec_wr_d;
            dn_addr_q    <= dn_addr_d;
            dn_data_q    <= dn_data_d;
            mod_q        <= mod_d;
            dip_q        <= dip_d;
            core_reset_q <= core_reset_d;
            rom_ready_q  <= rom_ready_d;
            load_err_q   <= load_err_d;
        end
    end

    assign prog_wr    = prog_wr_q;
    assign vec_wr     = vec_wr_q;
    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign mod        = mod_q;
    assign dip_sw     = dip_q;
    assign core_reset = core_reset_q;
    assign rom_ready  = rom_ready_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Bench for rom_load_ctrl: randomized download streams against a behavioural model.
// Latency: model predicts strobes one cycle after each write and release SETTLE+1 cycles after download falls.
// Backpressure: n/a.
module tb_rom_load_ctrl;
    import bwidow_pkg::*;

    localparam int P     = 256;
    localparam int V     = 128;
    localparam int S     = 20;
    localparam int TOTAL = P + V;

    logic        clk_12 = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic        prog_wr, vec_wr, core_reset, rom_ready, load_err;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data, mod;
    logic [63:0] dip_sw;

    rom_load_ctrl #(.PROG_BYTES(P), .VEC_BYTES(V), .SETTLE_CYCLES(S)) dut (
        .clk_12(clk_12), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index), .prog_wr(prog_wr), .vec_wr(vec_wr),
        .dn_addr(dn_addr), .dn_data(dn_data), .mod(mod), .dip_sw(dip_sw),
        .core_reset(core_reset), .rom_ready(rom_ready), .load_err(load_err)
    );

    always #5 clk_12 = ~clk_12;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: loading flag, byte tally, release deadline in clock edges
    bit          m_on = 0, m_loading = 0, m_err = 0, e_prog = 0, e_vec = 0, m_run = 0;
    int          m_cnt = 0;
    longint      cyc = 0, m_ready_at = -1;
    logic [15:0] e_addr = '0;
    logic [7:0]  e_data = '0, m_mod = '0;
    logic [63:0] m_dip = '0;

    always @(posedge clk_12) begin
        cyc++;
        m_on   = 1;
        e_prog = 0;
        e_vec  = 0;
        if (reset) begin
            m_loading = 0; m_cnt = 0; m_err = 0; m_ready_at = -1;
            m_mod = '0; m_dip = '0;
        end else begin
            if (ioctl_wr) begin
                if (ioctl_index == 8'd0 && m_loading) begin
                    m_cnt++;
                    if (ioctl_addr < P) begin
                        e_prog = 1; e_addr = ioctl_addr[15:0]; e_data = ioctl_dout;
                    end else if (ioctl_addr < TOTAL) begin
                        e_vec = 1; e_addr = 16'(ioctl_addr - P); e_data = ioctl_dout;
                    end
                end
                if (ioctl_index == 8'd1 && ioctl_addr == 0) m_mod = ioctl_dout;
                if (ioctl_index == 8'd254 && ioctl_addr < 8)
                    m_dip[int'(ioctl_addr[2:0]) * 8 +: 8] = ioctl_dout;
            end
            if (m_loading && !ioctl_download) begin
                m_loading = 0;
                if (m_cnt == TOTAL) m_ready_at = cyc + S;
                else m_err = 1;
            end else if (!m_loading && ioctl_download && ioctl_index == 8'd0) begin
                m_loading = 1; m_cnt = 0; m_err = 0; m_ready_at = -1;
            end
        end
        m_run = (m_ready_at >= 0) && (cyc >= m_ready_at);
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk_12) begin
        if (m_on) begin
            chk("prog_wr", prog_wr, e_prog);
            chk("vec_wr", vec_wr, e_vec);
            if (e_prog || e_vec) begin
                chk("dn_addr", dn_addr, e_addr);
                chk("dn_data", dn_data, e_data);
            end
            chk("mod", mod, m_mod);
            chk("dip_sw", dip_sw, m_dip);
            chk("core_reset", core_reset, !m_run);
            chk("rom_ready", rom_ready, m_run);
            chk("load_err", load_err, m_err);
        end
    end

    task automatic tick();
        @(posedge clk_12);
        #1;
    endtask

    // Index-0 stream of nbytes sequential bytes with random gaps; returns edges already past the fall
    task automatic rom_load(input int nbytes, input bit coincide, input int reset_at, output int edges);
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b0;
        tick();
        tick();
        for (int i = 0; i < nbytes; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = 8'($urandom);
            if (coincide && i == nbytes - 1) ioctl_download = 1'b0;
            if (i == reset_at) reset = 1'b1;
            tick();
            ioctl_wr = 1'b0;
            reset    = 1'b0;
            if (i == P - 1) chk("prog_last", {prog_wr, vec_wr, dn_addr}, {1'b1, 1'b0, 16'h00FF});
            if (i == P)     chk("vec_first", {prog_wr, vec_wr, dn_addr}, {1'b0, 1'b1, 16'h0000});
            if (i == reset_at) begin
                chk("rst_outputs", {prog_wr, vec_wr, dn_addr, dn_data, mod, core_reset, rom_ready, load_err},
                    {1'b0, 1'b0, 16'h0, 8'h0, 8'h0, 1'b1, 1'b0, 1'b0});
                chk("rst_dip", dip_sw, 64'h0);
            end
            if (i < nbytes - 1) repeat ($urandom_range(0, 2)) tick();
        end
        if (!coincide) begin
            ioctl_download = 1'b0;
            edges = 0;
        end else begin
            edges = 1;
        end
    endtask

    task automatic wait_ready(input int edges0, input string name);
        int n;
        bit seen;
        n    = edges0;
        seen = 0;
        while (n < S + 40 && !seen) begin
            tick();
            n++;
            if (rom_ready) seen = 1;
        end
        chk({name, "_latency"}, 64'(n), 64'(S + 1));
        chk({name, "_core_reset"}, core_reset, 1'b0);
        chk({name, "_load_err"}, load_err, 1'b0);
    endtask

    task automatic expect_fail(input string name);
        repeat (5) tick();
        chk({name, "_load_err"}, load_err, 1'b1);
        chk({name, "_core_reset"}, core_reset, 1'b1);
        chk({name, "_rom_ready"}, rom_ready, 1'b0);
    endtask

    task automatic side_write(input logic [7:0] idx, input int addr, input logic [7:0] data);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(addr);
        ioctl_dout = data;
        tick();
        ioctl_wr = 1'b0;
        tick();
        ioctl_download = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        reset = 1'b1;
        repeat (3) tick();
        chk("reset_state", {prog_wr, vec_wr, dn_addr, dn_data, mod, core_reset, rom_ready, load_err},
            {1'b0, 1'b0, 16'h0, 8'h0, 8'h0, 1'b1, 1'b0, 1'b0});
        chk("reset_dip", dip_sw, 64'h0);
        reset = 1'b0;
        repeat (3) tick();

        // Good load
        rom_load(TOTAL, 0, -1, e);
        wait_ready(e, "good1");

        // Live DIPs and game select in RUN
        side_write(IDX_DIP, 2, 8'h55);
        side_write(IDX_DIP, 9, 8'hAA);
        side_write(IDX_MOD, 0, 8'h03);
        side_write(IDX_MOD, 1, 8'h07);
        chk("dip_live", dip_sw, 64'h0000_0000_0055_0000);
        chk("mod_live", mod, MOD_SPACDUEL);
        chk("run_kept", {core_reset, rom_ready}, {1'b0, 1'b1});

        // Random traffic on other indices plus random DIP/mod bytes
        for (int k = 0; k < 24; k++) begin
            int sel;
            logic [7:0] idx;
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      idx = IDX_DIP;
            else if (sel == 1) idx = IDX_MOD;
            else if (sel == 2) idx = 8'd255;
            else               idx = 8'($urandom_range(2, 253));
            side_write(idx, int'($urandom_range(0, 11)), 8'($urandom));
        end
        chk("noise_run", {core_reset, rom_ready}, {1'b0, 1'b1});

        // Short load then recovery
        rom_load(TOTAL - 1, 0, -1, e);
        expect_fail("short");
        rom_load(TOTAL, 0, -1, e);
        wait_ready(e, "good2");

        // Overlong load
        rom_load(TOTAL + 4, 0, -1, e);
        expect_fail("overlong");

        // Reset mid-load: remainder is re-counted from zero and comes up short
        rom_load(TOTAL, 0, 100, e);
        expect_fail("rst_mid");

        // Last byte coincides with download falling
        rom_load(TOTAL, 1, -1, e);
        wait_ready(e, "coincide");

        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
